buf16x4_fill_ctrl: RTL and testbench

- Upstream feeder for the 16x4 line buffer (4 rows x 128 bits, 32-bit write port, byte-swapped internally).
- Streams 32-bit words from a 1-cycle-latency word memory and generates that buffer's write data, write enable, address and shift-up.
- Does an initial 4-row fill, then refills one row per consumer `next_row` request until the programmed row count is exhausted.

---
 rtl/buf16x4_fill_ctrl_pkg.sv | 32 +++
 rtl/buf16x4_addr_gen.sv | 83 ++++++++
 rtl/buf16x4_fill_ctrl.sv | 134 +++++++++++++
 tb/tb_buf16x4_fill_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buf16x4_fill_ctrl_pkg.sv
// Shared types and constants for the 16x4 line-buffer fill controller.
package buf16x4_fill_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_READY,
    ST_SHIFT,
    ST_REFILL,
    ST_FINISH
  } state_e;

  localparam int WORDS_PER_ROW = 4;
  localparam int BUF_ROWS      = 4;
  localparam int FILL_READS    = WORDS_PER_ROW * BUF_ROWS;

  // Buffer address layout: [8:6]=0, [5:4]=row, [3:0]=byte offset.
  localparam int BUF_ADDR_W  = 9;
  localparam int BUF_ROW_LSB = 4;
  localparam int BUF_OFS_LSB = 0;

  // Build a buffer write address from a row index and a word index.
  function automatic logic [BUF_ADDR_W-1:0] buf_addr_f(input logic [1:0] row,
                                                       input logic [1:0] word);
    logic [BUF_ADDR_W-1:0] a;
    a = '0;
    a[BUF_ROW_LSB +: 2] = row;
    a[BUF_OFS_LSB +: 4] = {word, 2'b00};
    return a;
  endfunction

endpackage

// File: rtl/buf16x4_addr_gen.sv
// Read-address generator and write-side pipeline for the line-buffer feeder.
// Keeps a running row base (base + r*stride built by accumulation), the
// word/row issue counters, and the write address/enable delayed one cycle
// to line up with the memory read latency.
module buf16x4_addr_gen
  import buf16x4_fill_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int ROWS_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ROWS_W-1:0]     row_stride,
  input  logic                  issue,
  input  logic                  refill,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  buf_we,
  output logic [BUF_ADDR_W-1:0] buf_addr
);

  logic [ADDR_W-1:0]     row_base_q, row_base_d;
  logic [ROWS_W-1:0]     stride_q, stride_d;
  logic [1:0]            word_q, word_d;
  logic [1:0]            fill_row_q, fill_row_d;
  logic                  we_q, we_d;
  logic [BUF_ADDR_W-1:0] waddr_q, waddr_d;

  // Next-state for the accumulator, counters and delayed write controls.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    row_base_d = row_base_q;
    stride_d   = stride_q;
    word_d     = word_q;
    fill_row_d = fill_row_q;
    we_d       = issue;
    waddr_d    = issue ? buf_addr_f(refill ? 2'd3 : fill_row_q, word_q) : '0;

    if (load) begin
      row_base_d = base_addr;
      stride_d   = row_stride;
      word_d     = '0;
      fill_row_d = '0;
    end else if (issue) begin
      if (word_q == 2'(WORDS_PER_ROW - 1)) begin
        word_d     = '0;
        row_base_d = row_base_q + ADDR_W'(stride_q);
        if (!refill) begin
          fill_row_d = fill_row_q + 2'd1;
        end
      end else begin
        word_d = word_q + 2'd1;
      end
    end
  end

  // State registers; reset also kills a read in flight so it never writes.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (rst) begin
      row_base_q <= '0;
      stride_q   <= '0;
      word_q     <= '0;
      fill_row_q <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
    end else begin
      row_base_q <= row_base_d;
      stride_q   <= stride_d;
      word_q     <= word_d;
      fill_row_q <= fill_row_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
    end
  end

  // Address wraps naturally modulo 2^ADDR_W; driven to zero when idle.
  assign mem_addr = issue ? (row_base_q + ADDR_W'(word_q)) : '0;
  assign buf_we   = we_q;
  assign buf_addr = waddr_q;

endmodule

// File: rtl/buf16x4_fill_ctrl.sv
// Upstream feeder for the 16x4 line buffer: initial 4-row fill from word
// memory, then one-row refills on each consumer next_row until the
// programmed row count is used up.
module buf16x4_fill_ctrl
  import buf16x4_fill_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int ROWS_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ROWS_W-1:0] row_stride,
  input  logic [ROWS_W-1:0] num_rows,
  input  logic              next_row,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       buf_wdata,
  output logic              buf_we,
  output logic [8:0]        buf_addr,
  output logic              buf_shift_up,
  output logic              buf_valid,
  output logic              done
);

  state_e            state_q, state_d;
  logic [4:0]        issue_cnt_q, issue_cnt_d;
  logic [ROWS_W-1:0] rows_fetched_q, rows_fetched_d;
  logic [ROWS_W-1:0] num_rows_q, num_rows_d;
  logic [4:0]        issue_limit;
  logic              load;
  logic              refill;

  assign issue_limit = (state_q == ST_FILL) ? 5'(FILL_READS) : 5'(WORDS_PER_ROW);
  assign refill      = (state_q == ST_REFILL);

  // Next-state and output decode; a phase ends on the cycle that carries
  // its last write with no read left to issue.
  always_comb begin
    state_d        = state_q;
    issue_cnt_d    = issue_cnt_q;
    rows_fetched_d = rows_fetched_q;
    num_rows_d     = num_rows_q;
    load           = 1'b0;
    mem_rd         = 1'b0;
    buf_shift_up   = 1'b0;
    buf_valid      = 1'b0;
    done           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && (num_rows >= ROWS_W'(BUF_ROWS))) begin
          load           = 1'b1;
          num_rows_d     = num_rows;
          rows_fetched_d = '0;
          issue_cnt_d    = '0;
          state_d        = ST_FILL;
        end
      end

      ST_FILL, ST_REFILL: begin
        mem_rd = (issue_cnt_q < issue_limit);
        if (mem_rd) begin
          issue_cnt_d = issue_cnt_q + 5'd1;
        end else if (buf_we) begin
          state_d        = ST_READY;
          rows_fetched_d = (state_q == ST_FILL) ? ROWS_W'(BUF_ROWS)
                                                : rows_fetched_q + ROWS_W'(1);
        end
      end

      ST_READY: begin
        buf_valid = 1'b1;
        if (next_row) begin
          if (rows_fetched_q < num_rows_q) begin
            issue_cnt_d = '0;
            state_d     = ST_SHIFT;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end

      ST_SHIFT: begin
        buf_shift_up = 1'b1;
        state_d      = ST_REFILL;
      end

      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      issue_cnt_q    <= '0;
      rows_fetched_q <= '0;
      num_rows_q     <= '0;
    end else begin
      state_q        <= state_d;
      issue_cnt_q    <= issue_cnt_d;
      rows_fetched_q <= rows_fetched_d;
      num_rows_q     <= num_rows_d;
    end
  end

  buf16x4_addr_gen #(
    .ADDR_W(ADDR_W),
    .ROWS_W(ROWS_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .base_addr (base_addr),
    .row_stride(row_stride),
    .issue     (mem_rd),
    .refill    (refill),
    .mem_addr  (mem_addr),
    .buf_we    (buf_we),
    .buf_addr  (buf_addr)
  );

  // Memory data is passed straight through while writing, zero otherwise.
  assign buf_wdata = buf_we ? mem_rdata : '0;

endmodule

// File: tb/tb_buf16x4_fill_ctrl.sv
// Self-checking bench for buf16x4_fill_ctrl: a word-memory model, a
// scoreboard of expected reads/writes, and one task per scenario.
module tb_buf16x4_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [7:0]  row_stride;
  logic [7:0]  num_rows;
  logic        next_row;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] buf_wdata;
  logic        buf_we;
  logic [8:0]  buf_addr;
  logic        buf_shift_up;
  logic        buf_valid;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_rd_q[$];
  logic [40:0] exp_wr_q[$];
  logic [15:0] exp_a;
  logic [40:0] exp_w;

  always #5 clk = ~clk;

  buf16x4_fill_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .row_stride  (row_stride),
    .num_rows    (num_rows),
    .next_row    (next_row),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .buf_wdata   (buf_wdata),
    .buf_we      (buf_we),
    .buf_addr    (buf_addr),
    .buf_shift_up(buf_shift_up),
    .buf_valid   (buf_valid),
    .done        (done)
  );

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'h5A5A, ~a};
  endfunction

  // One-cycle-latency word memory; garbage when not read.
  always @(posedge clk) mem_rdata <= mem_rd ? mem_word(mem_addr) : 32'hDEAD_BEEF;

  // Scoreboard monitor: pops expected reads and writes as the DUT produces them.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd) begin
        checks++;
        if (exp_rd_q.size() == 0) begin
          failures++;
          $display("FAIL rd_unexpected mem_addr=%h expected no read", mem_addr);
        end else begin
          exp_a = exp_rd_q.pop_front();
          if (mem_addr !== exp_a) begin
            failures++;
            $display("FAIL rd_addr got=%h exp=%h", mem_addr, exp_a);
          end
        end
      end
      if (buf_we) begin
        checks++;
        if (exp_wr_q.size() == 0) begin
          failures++;
          $display("FAIL wr_unexpected buf_addr=%h expected no write", buf_addr);
        end else begin
          exp_w = exp_wr_q.pop_front();
          if ({buf_addr, buf_wdata} !== exp_w) begin
            failures++;
            $display("FAIL wr_addr_data got=%h/%h exp=%h/%h",
                     buf_addr, buf_wdata, exp_w[40:32], exp_w[31:0]);
          end
        end
      end
      if (buf_we && buf_shift_up) begin
        checks++;
        failures++;
        $display("FAIL shift_we_overlap got both=1 exp not both");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the 4 reads of memory row r and their writes into buffer row brow.
  task automatic push_row(input logic [15:0] base, input logic [7:0] stride,
                          input int r, input int brow);
    logic [15:0] a;
    for (int w = 0; w < 4; w++) begin
      a = base + 16'(r * int'(stride) + w);
      exp_rd_q.push_back(a);
      exp_wr_q.push_back({9'(brow * 16 + w * 4), mem_word(a)});
    end
  endtask

  task automatic check_drained(input string tag);
    checks++;
    if (exp_rd_q.size() != 0 || exp_wr_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got rd_left=%0d wr_left=%0d exp 0/0",
               tag, exp_rd_q.size(), exp_wr_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; next_row = 1'b0;
    base_addr = '0; row_stride = '0; num_rows = '0;
    repeat (2) tick();
    checks++;
    if ({mem_rd, buf_we, buf_shift_up, buf_valid, done} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000",
               {mem_rd, buf_we, buf_shift_up, buf_valid, done});
    end
    checks++;
    if (mem_addr !== 16'h0 || buf_addr !== 9'h0 || buf_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h exp=0/0/0", mem_addr, buf_addr, buf_wdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill(input logic [15:0] base, input logic [7:0] stride,
                           input logic [7:0] nrows, input bit inject_next);
    int cyc;
    for (int r = 0; r < 4; r++) push_row(base, stride, r, r);
    base_addr = base; row_stride = stride; num_rows = nrows;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!buf_valid && cyc < 40) begin
      checks++;
      if (mem_rd !== (cyc <= 16)) begin
        failures++;
        $display("FAIL fill_rd_window cyc=%0d got=%b exp=%b", cyc, mem_rd, cyc <= 16);
      end
      next_row = inject_next && (cyc == 5);
      tick();
      cyc++;
    end
    next_row = 1'b0;
    checks++;
    if (cyc != 18) begin
      failures++;
      $display("FAIL fill_valid_cycle got=%0d exp=18", cyc);
    end
    check_drained("fill");
    repeat (2) begin
      tick();
      checks++;
      if (buf_valid !== 1'b1 || buf_shift_up !== 1'b0 || mem_rd !== 1'b0) begin
        failures++;
        $display("FAIL fill_ready_hold got v/s/r=%b%b%b exp=100",
                 buf_valid, buf_shift_up, mem_rd);
      end
    end
  endtask

  task automatic test_ignored_start_ready();
    base_addr = 16'h7777; row_stride = 8'h01; num_rows = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) begin
      checks++;
      if (mem_rd !== 1'b0 || buf_valid !== 1'b1) begin
        failures++;
        $display("FAIL start_in_ready got rd/valid=%b%b exp=01", mem_rd, buf_valid);
      end
      tick();
    end
  endtask

  task automatic test_refill(input logic [15:0] base, input logic [7:0] stride,
                             input int r, input bit with_start, input bit inject_next);
    int cyc;
    push_row(base, stride, r, 3);
    next_row = 1'b1;
    start = with_start;
    tick();
    next_row = 1'b0;
    start = 1'b0;
    checks++;
    if (buf_shift_up !== 1'b1 || buf_valid !== 1'b0 || mem_rd !== 1'b0) begin
      failures++;
      $display("FAIL refill_shift got s/v/r=%b%b%b exp=100", buf_shift_up, buf_valid, mem_rd);
    end
    cyc = 1;
    while (!buf_valid && cyc < 20) begin
      if (cyc >= 2) begin
        checks++;
        if (buf_shift_up !== 1'b0) begin
          failures++;
          $display("FAIL refill_shift_len cyc=%0d got=1 exp=0", cyc);
        end
      end
      next_row = inject_next && (cyc == 3);
      tick();
      cyc++;
    end
    next_row = 1'b0;
    checks++;
    if (cyc != 7) begin
      failures++;
      $display("FAIL refill_valid_cycle got=%0d exp=7", cyc);
    end
    check_drained("refill");
    tick();
    checks++;
    if (buf_valid !== 1'b1 || buf_shift_up !== 1'b0) begin
      failures++;
      $display("FAIL refill_ready_hold got v/s=%b%b exp=10", buf_valid, buf_shift_up);
    end
  endtask

  task automatic test_exhaust();
    next_row = 1'b1;
    tick();
    next_row = 1'b0;
    checks++;
    if (done !== 1'b1 || buf_valid !== 1'b0 || mem_rd !== 1'b0 || buf_shift_up !== 1'b0) begin
      failures++;
      $display("FAIL exhaust_done got d/v/r/s=%b%b%b%b exp=1000",
               done, buf_valid, mem_rd, buf_shift_up);
    end
    tick();
    checks++;
    if (done !== 1'b0 || buf_valid !== 1'b0 || mem_rd !== 1'b0) begin
      failures++;
      $display("FAIL exhaust_after got d/v/r=%b%b%b exp=000", done, buf_valid, mem_rd);
    end
    next_row = 1'b1;
    tick();
    next_row = 1'b0;
    checks++;
    if (buf_shift_up !== 1'b0 || done !== 1'b0 || buf_valid !== 1'b0 || mem_rd !== 1'b0) begin
      failures++;
      $display("FAIL idle_next_row got s/d/v/r=%b%b%b%b exp=0000",
               buf_shift_up, done, buf_valid, mem_rd);
    end
  endtask

  task automatic test_short_start();
    base_addr = 16'h0500; row_stride = 8'h10; num_rows = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) begin
      checks++;
      if (mem_rd !== 1'b0 || buf_we !== 1'b0 || buf_valid !== 1'b0) begin
        failures++;
        $display("FAIL short_start got r/w/v=%b%b%b exp=000", mem_rd, buf_we, buf_valid);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_refill(input logic [15:0] base, input logic [7:0] stride,
                                       input int r);
    push_row(base, stride, r, 3);
    next_row = 1'b1;
    tick();
    next_row = 1'b0;
    tick();
    tick();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_rd, buf_we, buf_shift_up, buf_valid, done} !== 5'b0 ||
        mem_addr !== 16'h0 || buf_addr !== 9'h0 || buf_wdata !== 32'h0) begin
      failures++;
      $display("FAIL midreset_outputs got=%b %h %h %h exp=00000 0 0 0",
               {mem_rd, buf_we, buf_shift_up, buf_valid, done}, mem_addr, buf_addr, buf_wdata);
    end
    tick();
    checks++;
    if (buf_we !== 1'b0 || mem_rd !== 1'b0) begin
      failures++;
      $display("FAIL midreset_no_write got we/rd=%b%b exp=00", buf_we, mem_rd);
    end
    checks++;
    if (exp_rd_q.size() != 2 || exp_wr_q.size() != 3) begin
      failures++;
      $display("FAIL midreset_progress got rd_left=%0d wr_left=%0d exp 2/3",
               exp_rd_q.size(), exp_wr_q.size());
    end
    exp_rd_q.delete();
    exp_wr_q.delete();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill(16'h0100, 8'h10, 8'd6, 1'b1);
    test_ignored_start_ready();
    test_refill(16'h0100, 8'h10, 4, 1'b1, 1'b1);
    test_refill(16'h0100, 8'h10, 5, 1'b0, 1'b0);
    test_exhaust();
    test_short_start();
    test_fill(16'hFFFE, 8'h04, 8'd4, 1'b0);
    test_exhaust();
    test_fill(16'h0200, 8'h20, 8'd8, 1'b0);
    test_reset_mid_refill(16'h0200, 8'h20, 4);
    test_fill(16'h0300, 8'h08, 8'd5, 1'b0);
    test_refill(16'h0300, 8'h08, 4, 1'b0, 1'b0);
    test_exhaust();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
